// File: rtl/controller.sv
// Multicycle instruction-sequencing controller: decodes a 16-bit instruction and steps the datapath through fetch/decode/execute.
// Latency: ALU/MOV/STOR 4 cycles, LOAD 5, taken JCOND 3 (FETCH and LOAD add wait cycles when memory wait is enabled).
// Backpressure: with CONTROLLER_MEM_WAIT_EN defined, FETCH and LOAD hold until mem_ready=1; otherwise mem_ready is ignored.
//
// Ports: clk/reset (synchronous, active-high); instr, psr_z, mem_ready in;
//        datapath selects (wa_s, pc_s, alub_s, wd_s, alua_s, alucont), enables (pcen, regwrite,
//        irwrite, psr_we, mem_re, mem_we), addr_s, debug state, illegal_op pulse out.
// Optional feature macro: CONTROLLER_MEM_WAIT_EN (memory wait states on FETCH and LOAD).
module controller #(
    parameter int INSTR_W   = 16,
    parameter int STATEBITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [INSTR_W-1:0]   instr,
    input  logic                 psr_z,
    input  logic                 mem_ready,
    output logic                 wa_s,
    output logic                 pc_s,
    output logic                 alub_s,
    output logic [1:0]           wd_s,
    output logic [1:0]           alua_s,
    output logic [2:0]           alucont,
    output logic                 pcen,
    output logic                 regwrite,
    output logic                 irwrite,
    output logic                 psr_we,
    output logic                 mem_re,
    output logic                 mem_we,
    output logic                 addr_s,
    output logic [STATEBITS-1:0] state,
    output logic                 illegal_op
);

    typedef enum logic [STATEBITS-1:0] {
        S_FETCH  = STATEBITS'(0),
        S_DECODE = STATEBITS'(1),
        S_ALU_R  = STATEBITS'(2),
        S_ALU_I  = STATEBITS'(3),
        S_MOV    = STATEBITS'(4),
        S_LOAD   = STATEBITS'(5),
        S_LOADWB = STATEBITS'(6),
        S_STORE  = STATEBITS'(7),
        S_JUMP   = STATEBITS'(8),
        S_PCINC  = STATEBITS'(9)
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1011;
    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MEM = 4'b0100;

    state_t state_q;

    logic [3:0] op, cond, ext;
    assign op   = instr[15:12];
    assign cond = instr[11:8];
    assign ext  = instr[7:4];

    // {legal, writes Rdest, updates flags, alucont[2:0]}
    function automatic logic [5:0] alu_decode(input logic [3:0] code);
        case (code)
            OP_ADD:  return 6'b111_000;
            OP_SUB:  return 6'b111_001;
            OP_CMP:  return 6'b101_001;
            OP_AND:  return 6'b110_010;
            OP_OR:   return 6'b110_011;
            OP_XOR:  return 6'b110_100;
            default: return 6'b000_000;
        endcase
    endfunction

    logic [5:0] alu_r, alu_i, alu_sel;
    logic       is_rtype, cls_alu_r, cls_alu_i, cls_mov, cls_load, cls_store, cls_jump, cls_illegal;
    logic       jump_taken, mem_go;

    assign alu_r   = alu_decode(ext);
    assign alu_i   = alu_decode(op);
    assign alu_sel = (state_q == S_ALU_I) ? alu_i : alu_r;

    assign is_rtype    = (op == 4'b0000);
    assign cls_alu_r   = is_rtype && alu_r[5];
    assign cls_alu_i   = alu_i[5];              // op 0000/0100/1101 never decode as ALU ops
    assign cls_mov     = (is_rtype && ext == OP_MOV) || (op == OP_MOV);
    assign cls_load    = (op == OP_MEM) && (ext == 4'b0000);
    assign cls_store   = (op == OP_MEM) && (ext == 4'b0100);
    assign cls_jump    = (op == OP_MEM) && (ext == 4'b1100);
    assign cls_illegal = !(cls_alu_r || cls_alu_i || cls_mov || cls_load || cls_store || cls_jump);

    always_comb begin
        case (cond)
            4'b0000: jump_taken = psr_z;
            4'b0001: jump_taken = !psr_z;
            4'b1110: jump_taken = 1'b1;
            default: jump_taken = 1'b0;
        endcase
    end

`ifdef CONTROLLER_MEM_WAIT_EN
    assign mem_go = mem_ready;
    logic unused_ok;
    assign unused_ok = ^instr[3:0];
`else
    assign mem_go = 1'b1;
    logic unused_ok;
    assign unused_ok = ^{instr[3:0], mem_ready};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  if (mem_go) state_q <= S_DECODE;
                S_DECODE: begin
                    if (cls_alu_r)      state_q <= S_ALU_R;
                    else if (cls_alu_i) state_q <= S_ALU_I;
                    else if (cls_mov)   state_q <= S_MOV;
                    else if (cls_load)  state_q <= S_LOAD;
                    else if (cls_store) state_q <= S_STORE;
                    else if (cls_jump)  state_q <= S_JUMP;
                    else                state_q <= S_PCINC;
                end
                S_ALU_R, S_ALU_I, S_MOV, S_LOADWB, S_STORE: state_q <= S_PCINC;
                S_LOAD:   if (mem_go) state_q <= S_LOADWB;
                S_JUMP:   state_q <= jump_taken ? S_FETCH : S_PCINC;
                S_PCINC:  state_q <= S_FETCH;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    // Moore outputs; reset masks everything so an abandoned instruction writes nothing.
    always_comb begin
        wa_s = 1'b0; pc_s = 1'b0; alub_s = 1'b0; wd_s = 2'd0; alua_s = 2'd0; alucont = 3'd0;
        pcen = 1'b0; regwrite = 1'b0; irwrite = 1'b0; psr_we = 1'b0;
        mem_re = 1'b0; mem_we = 1'b0; addr_s = 1'b0; illegal_op = 1'b0;
        state = reset ? '0 : state_q;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    irwrite = 1'b1;
                    mem_re  = 1'b1;
                end
                S_DECODE: illegal_op = cls_illegal;
                S_ALU_R, S_ALU_I: begin
                    alua_s   = (state_q == S_ALU_I) ? 2'd2 : 2'd0;
                    alucont  = alu_sel[2:0];
                    regwrite = alu_sel[4];
                    wa_s     = alu_sel[4];
                    wd_s     = alu_sel[4] ? 2'd3 : 2'd0;
                    psr_we   = alu_sel[3];
                end
                S_MOV: begin
                    regwrite = 1'b1;
                    wa_s     = 1'b1;
                    wd_s     = is_rtype ? 2'd1 : 2'd0;
                end
                S_LOAD: begin
                    mem_re = 1'b1;
                    addr_s = 1'b1;
                end
                S_LOADWB: begin
                    regwrite = 1'b1;
                    wa_s     = 1'b1;
                    wd_s     = 2'd2;
                end
                S_STORE: begin
                    mem_we = 1'b1;
                    addr_s = 1'b1;
                end
                S_JUMP: pcen = jump_taken;
                S_PCINC: begin
                    alua_s = 2'd1;
                    alub_s = 1'b1;
                    pc_s   = 1'b1;
                    pcen   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: state-sequence table, hand-written corner sequences,
// then randomized instructions checked cycle-by-cycle against an instruction-level reference model.
module tb_controller;

    logic        clk = 1'b0;
    logic        reset, psr_z, mem_ready;
    logic [15:0] instr;
    logic        wa_s, pc_s, alub_s, pcen, regwrite, irwrite, psr_we, mem_re, mem_we, addr_s, illegal_op;
    logic [1:0]  wd_s, alua_s;
    logic [2:0]  alucont;
    logic [3:0]  state;

    always #5 clk = ~clk;

    controller #(.INSTR_W(16), .STATEBITS(4)) dut (
        .clk(clk), .reset(reset), .instr(instr), .psr_z(psr_z), .mem_ready(mem_ready),
        .wa_s(wa_s), .pc_s(pc_s), .alub_s(alub_s), .wd_s(wd_s), .alua_s(alua_s), .alucont(alucont),
        .pcen(pcen), .regwrite(regwrite), .irwrite(irwrite), .psr_we(psr_we), .mem_re(mem_re),
        .mem_we(mem_we), .addr_s(addr_s), .state(state), .illegal_op(illegal_op)
    );

    typedef struct packed {
        logic       wa_s;
        logic       pc_s;
        logic       alub_s;
        logic [1:0] wd_s;
        logic [1:0] alua_s;
        logic [2:0] alucont;
        logic       pcen;
        logic       regwrite;
        logic       irwrite;
        logic       psr_we;
        logic       mem_re;
        logic       mem_we;
        logic       addr_s;
        logic       illegal_op;
    } ctl_t;

    typedef struct {
        logic [3:0] st;
        ctl_t       c;
    } step_t;

    typedef struct {
        logic [15:0] instr;
        logic        z;
        int          n;
        logic [23:0] sts;   // expected states, first in the top nibble
    } vec_t;

    ctl_t  got;
    assign got = {wa_s, pc_s, alub_s, wd_s, alua_s, alucont, pcen, regwrite, irwrite, psr_we,
                  mem_re, mem_we, addr_s, illegal_op};

    step_t trace[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_fetch();
        for (int i = 0; i < 10 && state != 4'd0; i++) step();
        chk("return_to_fetch", state, 4'd0);
    endtask

    // ALU semantics of an opcode: legality, result code, writes Rdest, sets flags.
    function automatic void alu_ref(input logic [3:0] code, output bit ok, output logic [2:0] ac,
                                    output bit wr, output bit fl);
        ok = 1; wr = 1; fl = 0; ac = 3'd0;
        case (code)
            4'h5: begin ac = 3'd0; fl = 1; end
            4'h9: begin ac = 3'd1; fl = 1; end
            4'hB: begin ac = 3'd1; fl = 1; wr = 0; end
            4'h1: ac = 3'd2;
            4'h2: ac = 3'd3;
            4'h3: ac = 3'd4;
            default: ok = 0;
        endcase
    endfunction

    // Expected per-cycle state and outputs for one whole instruction, from its meaning.
    function automatic void build_trace(input logic [15:0] ins, input logic z);
        logic [3:0] op, cnd, ext;
        bit   ok, wr, fl, imm, taken;
        logic [2:0] ac;
        ctl_t c;
        int   kind;   // 0 alu, 1 mov, 2 load, 3 store, 4 jump, 5 illegal
        op = ins[15:12]; cnd = ins[11:8]; ext = ins[7:4];
        imm = (op != 4'h0);
        alu_ref(imm ? op : ext, ok, ac, wr, fl);
        if (op == 4'h0)      kind = (ext == 4'hD) ? 1 : (ok ? 0 : 5);
        else if (op == 4'h4) kind = (ext == 4'h0) ? 2 : (ext == 4'h4) ? 3 : (ext == 4'hC) ? 4 : 5;
        else if (op == 4'hD) kind = 1;
        else                 kind = ok ? 0 : 5;
        taken = (cnd == 4'h0) ? z : (cnd == 4'h1) ? !z : (cnd == 4'hE);

        trace.delete();
        c = '0; c.irwrite = 1; c.mem_re = 1;  trace.push_back('{4'd0, c});
        c = '0; c.illegal_op = (kind == 5);   trace.push_back('{4'd1, c});
        c = '0;
        case (kind)
            0: begin
                c.alua_s = imm ? 2'd2 : 2'd0; c.alucont = ac; c.psr_we = fl;
                c.regwrite = wr; c.wa_s = wr; c.wd_s = wr ? 2'd3 : 2'd0;
                trace.push_back('{imm ? 4'd3 : 4'd2, c});
            end
            1: begin
                c.regwrite = 1; c.wa_s = 1; c.wd_s = imm ? 2'd0 : 2'd1;
                trace.push_back('{4'd4, c});
            end
            2: begin
                c.mem_re = 1; c.addr_s = 1; trace.push_back('{4'd5, c});
                c = '0; c.regwrite = 1; c.wa_s = 1; c.wd_s = 2'd2; trace.push_back('{4'd6, c});
            end
            3: begin
                c.mem_we = 1; c.addr_s = 1; trace.push_back('{4'd7, c});
            end
            4: begin
                c.pcen = taken; trace.push_back('{4'd8, c});
            end
            default: ;
        endcase
        if (!(kind == 4 && taken)) begin
            c = '0; c.alua_s = 2'd1; c.alub_s = 1; c.pc_s = 1; c.pcen = 1;
            trace.push_back('{4'd9, c});
        end
    endfunction

    task automatic run_model(input logic [15:0] ins, input logic z);
        build_trace(ins, z);
        instr = ins;
        psr_z = z;
        foreach (trace[k]) begin
`ifndef CONTROLLER_MEM_WAIT_EN
            mem_ready = 1'($urandom);
`endif
            chk($sformatf("model_state i=%h k=%0d", ins, k), state, trace[k].st);
            chk($sformatf("model_outs i=%h k=%0d", ins, k), got, trace[k].c);
            step();
        end
    endtask

    vec_t       tbl[12];
    logic [3:0] codes[7];
    logic [3:0] conds[4];
    logic [3:0] exts[4];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{16'h0351, 1'b0, 4, 24'h012900};  // ADD
        tbl[1]  = '{16'h5207, 1'b0, 4, 24'h013900};  // ADDI
        tbl[2]  = '{16'h4104, 1'b0, 5, 24'h015690};  // LOAD
        tbl[3]  = '{16'h4241, 1'b0, 4, 24'h017900};  // STOR
        tbl[4]  = '{16'h40C2, 1'b1, 3, 24'h018000};  // JEQ taken
        tbl[5]  = '{16'h40C2, 1'b0, 4, 24'h018900};  // JEQ not taken
        tbl[6]  = '{16'h41C2, 1'b0, 3, 24'h018000};  // JNE taken
        tbl[7]  = '{16'h4EC0, 1'b0, 3, 24'h018000};  // always
        tbl[8]  = '{16'h42C0, 1'b1, 4, 24'h018900};  // never-taken code
        tbl[9]  = '{16'h0BB2, 1'b0, 4, 24'h012900};  // CMP
        tbl[10] = '{16'hD305, 1'b0, 4, 24'h014900};  // MOVI
        tbl[11] = '{16'hF000, 1'b0, 3, 24'h019000};  // illegal
        codes = '{4'h5, 4'h9, 4'hB, 4'h1, 4'h2, 4'h3, 4'hD};
        conds = '{4'h0, 4'h1, 4'hE, 4'h7};
        exts  = '{4'h0, 4'h4, 4'hC, 4'h8};

        // Reset: everything zero while held, even with an instruction present.
        reset = 1; instr = 16'h0351; psr_z = 0; mem_ready = 1;
        step(); step();
        chk("reset_state", state, 4'd0);
        chk("reset_outs", got, 32'd0);
        reset = 0;
        #1;
        chk("first_fetch_irwrite", irwrite, 1'b1);
        chk("first_fetch_mem_re", mem_re, 1'b1);

        // State-sequence table.
        foreach (tbl[v]) begin
            instr = tbl[v].instr;
            psr_z = tbl[v].z;
            for (int k = 0; k < tbl[v].n; k++) begin
                chk($sformatf("tbl%0d_state%0d", v, k), state, tbl[v].sts[23 - 4 * k -: 4]);
                step();
            end
        end
        chk("tbl_end_fetch", state, 4'd0);

        // ADD R3,R1 execute cycle.
        instr = 16'h0351; step(); step();
        chk("add_state", state, 4'd2);
        chk("add_regwrite", regwrite, 1'b1);
        chk("add_wd_s", wd_s, 2'd3);
        chk("add_alucont", alucont, 3'd0);
        chk("add_psr_we", psr_we, 1'b1);
        sync_fetch();

        // ADDI then PCINC.
        instr = 16'h5207; step(); step();
        chk("addi_state", state, 4'd3);
        chk("addi_alua_s", alua_s, 2'd2);
        chk("addi_regwrite", regwrite, 1'b1);
        step();
        chk("pcinc_state", state, 4'd9);
        chk("pcinc_ctl", {pcen, pc_s, alub_s, alua_s, alucont}, {1'b1, 1'b1, 1'b1, 2'd1, 3'd0});
        sync_fetch();

        // CMP: flags only.
        instr = 16'h0BB2; step(); step();
        chk("cmp_regwrite", regwrite, 1'b0);
        chk("cmp_psr_we", psr_we, 1'b1);
        chk("cmp_alucont", alucont, 3'd1);
        sync_fetch();

        // Illegal: one-cycle pulse, then PCINC.
        instr = 16'hF000; step();
        chk("illegal_pulse", illegal_op, 1'b1);
        step();
        chk("illegal_drop", illegal_op, 1'b0);
        chk("illegal_to_pcinc", state, 4'd9);
        sync_fetch();

        // JEQ taken straight back to FETCH.
        instr = 16'h40C2; psr_z = 1; step(); step();
        chk("jeq_ctl", {state, pcen, pc_s}, {4'd8, 1'b1, 1'b0});
        step();
        chk("jeq_to_fetch", state, 4'd0);

        // Reset during LOADWB abandons the write.
        instr = 16'h4104; psr_z = 0; step(); step(); step();
        chk("ldwb_state", state, 4'd6);
        chk("ldwb_regwrite", regwrite, 1'b1);
        reset = 1; #1;
        chk("rst_mid_regwrite", regwrite, 1'b0);
        chk("rst_mid_outs", got, 32'd0);
        step();
        chk("rst_mid_state", state, 4'd0);
        chk("rst_mid_outs2", got, 32'd0);
        reset = 0; #1;
        chk("rst_mid_fetch", {state, irwrite}, {4'd0, 1'b1});
        sync_fetch();

`ifdef CONTROLLER_MEM_WAIT_EN
        // FETCH and LOAD wait for mem_ready.
        instr = 16'h4104; mem_ready = 0;
        step();
        chk("fetch_hold", {state, irwrite}, {4'd0, 1'b1});
        mem_ready = 1; step(); step();
        chk("load_enter", state, 4'd5);
        mem_ready = 0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("load_hold%0d", k), {state, mem_re, addr_s}, {4'd5, 1'b1, 1'b1});
            step();
        end
        chk("load_hold3", state, 4'd5);
        mem_ready = 1; step();
        chk("loadwb_ctl", {state, wd_s, regwrite}, {4'd6, 2'd2, 1'b1});
        sync_fetch();
`else
        // mem_ready ignored: memory states last one cycle.
        instr = 16'h4104; mem_ready = 0;
        step();
        chk("fetch_no_wait", state, 4'd1);
        step(); step();
        chk("load_no_wait", state, 4'd6);
        mem_ready = 1;
        sync_fetch();
`endif

        // Randomized instructions against the reference model.
        for (int n = 0; n < 300; n++) begin
            logic [15:0] ins;
            ins = 16'($urandom);
            case ($urandom_range(0, 3))
                0: ;
                1: ins = {4'h0, ins[11:8], codes[$urandom_range(0, 6)], ins[3:0]};
                2: ins = {codes[$urandom_range(0, 6)], ins[11:0]};
                default: ins = {4'h4, conds[$urandom_range(0, 3)], exts[$urandom_range(0, 3)], ins[3:0]};
            endcase
            run_model(ins, 1'($urandom));
        end
        chk("final_fetch", state, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 Parameter: INSTR_W, 16, instruction width; all decode fields are positioned for 16.
REQ-002 Parameter: STATEBITS, 4, width of the state register and the state debug port.
REQ-003 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: instr  input  INSTR_W  instruction register contents; valid from DECODE onward.
REQ-006 Port: psr_z  input  1  zero flag from the processor status register.
REQ-007 Port: mem_ready  input  1  memory access complete; ignored unless MEM_WAIT_EN is defined.
REQ-008 Port: wa_s, pc_s, alub_s  output  1 each  datapath mux2 selects.
REQ-009 Port: wd_s, alua_s  output  2 each  datapath mux4 selects.
REQ-010 Port: alucont  output  3  ALU operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
REQ-011 Port: pcen, regwrite, irwrite, psr_we, mem_re, mem_we, addr_s  output  1 each  write enables and memory address select (0 = PC, 1 = Rsrc).
REQ-012 Port: state  output  STATEBITS  current state encoding, for debug.
REQ-013 Port: illegal_op  output  1  one-cycle pulse on an undecodable instruction.

Function
REQ-014 Decode fields: op = instr[15:12], cond/Rdest = instr[11:8], ext = instr[7:4]; R-type when op = 0000.
REQ-015 Operation codes (ext for R-type, op for immediate forms): 0101 ADD, 1001 SUB, 1011 CMP, 0001 AND, 0010 OR, 0011 XOR, 1101 MOV.
REQ-016 op 0100 selects by ext: 0000 LOAD, 0100 STOR, 1100 JCOND.
REQ-017 Moore FSM; outputs are combinational from the registered state plus instr/psr_z; every signal not listed for a state is 0.
REQ-018 Datapath select codes:
- wd_s: 0 imm, 1 Rsrc, 2 mem, 3 alu.
- alua_s: 0 Rsrc, 1 PC, 2 imm_ext, 3 zero.
- alub_s: 0 Rdest, 1 one.
- pc_s: 0 Rsrc, 1 alu.
- wa_s: 1 Rdest.
REQ-019 FETCH (0): irwrite=1, mem_re=1, addr_s=0; next state DECODE.
REQ-020 DECODE (1): no enables asserted. Next state by instruction class: ALU_R, ALU_I, MOV, LOAD, STORE or JUMP. An illegal encoding pulses illegal_op and goes to PCINC.
REQ-021 ALU_R (2): alua_s=0, alub_s=0, alucont per ext. Writes Rdest from the ALU (regwrite=1, wa_s=1, wd_s=3) except for CMP. psr_we=1 for ADD, SUB and CMP. Next state PCINC.
REQ-022 ALU_I (3): same as ALU_R but alua_s=2 (imm_ext); alucont is taken from op. Next state PCINC.
REQ-023 MOV (4): regwrite=1, wa_s=1; wd_s=1 (MOV) or 0 (MOVI). Next state PCINC.
REQ-024 LOAD (5): mem_re=1, addr_s=1; next state LOADWB.
REQ-025 LOADWB (6): regwrite=1, wa_s=1, wd_s=2; next state PCINC.
REQ-026 STORE (7): mem_we=1, addr_s=1; next state PCINC.
REQ-027 JUMP (8), taken: pcen=1, pc_s=0, next state FETCH.
- Conditions: cond 0000 taken if psr_z=1; 0001 taken if psr_z=0; 1110 always taken; all other codes never taken.
- Not taken: next state PCINC.
REQ-028 PCINC (9): alua_s=1, alub_s=1, alucont=000, pc_s=1, pcen=1; next state FETCH.
REQ-029 Unused state encodings SHALL transition to FETCH on the next cycle with all outputs 0.
REQ-030 Latency without wait states: ALU, MOV and STOR take 4 cycles; LOAD takes 5; a taken JCOND takes 3.

Reset
REQ-031 While reset=1 at a clock edge, state becomes FETCH.
REQ-032 While reset is held, all outputs SHALL be forced to 0.
REQ-033 The first FETCH outputs appear in the cycle after reset deasserts.
REQ-034 Reset asserted mid-instruction abandons the instruction: no pcen, regwrite or mem_we is asserted in or after the reset cycle.

Configuration
REQ-035 Macro CONTROLLER_MEM_WAIT_EN defined: FETCH and LOAD hold their state and outputs until mem_ready=1, then advance.
REQ-036 Macro CONTROLLER_MEM_WAIT_EN undefined: mem_ready is ignored and every memory state lasts exactly one cycle.

Verification
REQ-037 reset, then instr=0x0351 (ADD R3,R1) -> states 0,1,2,9,0; in state 2 regwrite=1, wd_s=3, alucont=000, psr_we=1.
REQ-038 instr=0x5207 (ADDI R2,#7) -> state 3 with alua_s=2, regwrite=1; then PCINC with pcen=1, pc_s=1, alub_s=1.
REQ-039 instr=0x4104 (LOAD), macro defined, mem_ready held low 3 cycles in LOAD -> state 5 held 4 cycles, then state 6 with wd_s=2, regwrite=1.
REQ-040 instr=0x40C2 (JEQ R2): psr_z=1 -> JUMP with pcen=1, pc_s=0, then FETCH; psr_z=0 -> PCINC.
REQ-041 instr=0x0BB2 (CMP) -> regwrite=0, psr_we=1, alucont=001; instr=0xF000 -> illegal_op pulses for exactly 1 cycle, then PCINC.
REQ-042 reset pulsed during LOADWB -> regwrite=0 from that edge on, state=0 next cycle.
